warp_scheduler: RTL and testbench
=================================

# warp_scheduler

Sequences the per-warp scalar register files and the shared fetch/decode/execute datapath of one compute core. Holds a launched set of warps and interleaves them round-robin at instruction granularity. For the selected warp it steps a shared warp state through fetch, decode, register request, execute or memory wait, and update. It drives the `enable` and `warp_state` inputs of every `scalar_reg_file` instance.

## Interface

Parameters:
- `NUM_WARPS`, default 4: warps per core, power of two, 2..16.
- `WARP_IDX_W`, default `$clog2(NUM_WARPS)`: warp index width.

Ports:
- `clk`, in, 1: clock.
- `reset`, in, 1: synchronous, active-high.
- `start`, in, 1: launch request. Sampled only in IDLE or DONE.
- `warp_valid_mask`, in, NUM_WARPS: warps to run. Captured on an accepted `start`.
- `fetch_req`, out, 1: instruction fetch request for `active_warp`.
- `fetch_ready`, in, 1: instruction delivered this cycle.
- `decoded_halt`, in, 1: current instruction is a halt. Valid in DECODE.
- `decoded_mem_access`, in, 1: current instruction uses the LSU. Valid in REQUEST.
- `lsu_done`, in, 1: LSU result valid. Meaningful in WAIT.
- `active_warp`, out, WARP_IDX_W: currently scheduled warp.
- `warp_enable`, out, NUM_WARPS: one-hot enable to the register files.
- `warp_state`, out, `warp_state_t`: broadcast state.
- `warp_done_mask`, out, NUM_WARPS: warps that have halted.
- `done`, out, 1: all launched warps have halted.

## Operation

- States: IDLE, FETCH, DECODE, REQUEST, WAIT, EXECUTE, UPDATE, DONE.
- IDLE/DONE with `start`=1:
  - Capture `warp_valid_mask` into `pending`.
  - Clear `warp_done_mask`.
  - If `pending`≠0: `active_warp` = lowest set index, go to FETCH.
  - If `pending`=0: go to DONE.
- FETCH: `fetch_req`=1 until `fetch_ready`, then go to DECODE.
- DECODE:
  - `decoded_halt`=1: clear `pending[active_warp]`, set `warp_done_mask[active_warp]`, then select the next warp (below).
  - Otherwise go to REQUEST.
- REQUEST: one cycle for the register read. Then go to WAIT if `decoded_mem_access`, else EXECUTE.
- WAIT: hold until `lsu_done`, then go to UPDATE.
- EXECUTE: one cycle, then go to UPDATE.
- UPDATE: one cycle; the register file writes back here. Then select the next warp.
- Next-warp selection:
  - Pick the first set bit of `pending`, searching `active_warp+1` upward with wrap-around and ending at `active_warp` itself.
  - If one is found, load `active_warp` and go to FETCH. If `pending`=0, go to DONE.
- `warp_enable` = one-hot(`active_warp`) in every state except IDLE and DONE, where it is 0.
- `warp_state` equals the scheduler state. IDLE and DONE both map to WARP_IDLE/WARP_DONE.
- `done`=1 exactly while in DONE.
- `start` outside IDLE/DONE is ignored.
- `lsu_done` outside WAIT is ignored.
- `fetch_ready` outside FETCH is ignored.

## Timing

- Reset values, effective the cycle after `reset` is sampled:
  - state IDLE.
  - `active_warp`=0, `warp_enable`=0, `fetch_req`=0.
  - `warp_done_mask`=0, `pending`=0, `done`=0.
- Reset mid-operation: abandon the instruction immediately. No UPDATE cycle is issued.
- All outputs are registered-state decodes. No combinational path from inputs to outputs.
- Minimum cycles per instruction, with `fetch_ready` in the first FETCH cycle:
  - ALU: 5 (FETCH, DECODE, REQUEST, EXECUTE, UPDATE).
  - Memory: 5 + (WAIT cycles − 1).
- Halt costs 2 cycles (FETCH, DECODE).
- Warp switch has zero bubble: the cycle after UPDATE is FETCH of the next warp.
- `start` to first FETCH: 1 cycle. Last UPDATE or halting DECODE to `done`: 1 cycle.
- A single pending warp runs back-to-back with no other warp interleaved.

## Structure

- Shared package (`common.svh`):
  - `warp_state_t`, with WARP_IDLE, WARP_FETCH, WARP_DECODE, WARP_REQUEST, WARP_WAIT, WARP_EXECUTE, WARP_UPDATE, WARP_DONE.
  - `NUM_WARPS` default.
- Sub-module `rr_picker`: combinational rotating priority picker.
  - Inputs: request mask, current index.
  - Outputs: `found`, next index.
- The scheduler is the FSM, the `pending`/done registers, and the output decode.

## Test plan

- Launch: `warp_valid_mask`=4'b0101, `fetch_ready` tied 1, no halts, ALU only.
  - `active_warp` sequence 0,2,0,2…, one switch every 5 cycles.
  - `warp_enable` alternates 0001/0100.
- Fetch stall and memory wait: `fetch_ready` delayed 3 cycles, `decoded_mem_access`=1, `lsu_done` after 4 WAIT cycles.
  - FETCH lasts 3 cycles and WAIT lasts 4.
  - UPDATE occurs exactly once.
- Halts: mask 4'b1111; warp 1 then warp 3 halt on their first instruction.
  - `warp_done_mask` becomes 0010, then 1010.
  - Order continues 0,2,0,2.
  - Once all four have halted, `done`=1 one cycle after the last halt.
- Empty launch: `start` with mask 0 → DONE next cycle with `done`=1 and `warp_enable`=0. A later `start` with mask 0001 relaunches.
- Reset in WAIT: assert `reset` for 1 cycle.
  - Next cycle: IDLE with all outputs at reset values.
  - No WARP_UPDATE is observed.
  - `start` in the middle of a run is ignored.

Source files
------------

// File: rtl/warp_scheduler_pkg.sv
// Shared types and defaults for the warp scheduler and the register files it drives.
package warp_scheduler_pkg;

    localparam int NUM_WARPS_DEFAULT = 4;

    // Broadcast pipeline state; the scheduler FSM uses the same encoding directly.
    typedef enum logic [2:0] {
        WARP_IDLE,
        WARP_FETCH,
        WARP_DECODE,
        WARP_REQUEST,
        WARP_WAIT,
        WARP_EXECUTE,
        WARP_UPDATE,
        WARP_DONE
    } warp_state_t;

endpackage

// File: rtl/warp_scheduler_rr_picker.sv
// Rotating priority picker: finds the first set request bit after cur_idx,
// wrapping around and ending at cur_idx itself.
module warp_scheduler_rr_picker #(
    parameter int N = 4,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] req_mask,
    input  logic [W-1:0] cur_idx,
    output logic         found,
    output logic [W-1:0] next_idx
);

    logic [W-1:0] cand;

    // Walk cur_idx+1 .. cur_idx+N; N is a power of two so the index wraps naturally.
    always_comb begin
        found    = 1'b0;
        next_idx = cur_idx;
        cand     = '0;
        for (int k = 1; k <= N; k++) begin
            cand = cur_idx + W'(k);
            if (!found && req_mask[cand]) begin
                found    = 1'b1;
                next_idx = cand;
            end
        end
    end

endmodule

// File: rtl/warp_scheduler.sv
// Round-robin warp scheduler: steps one shared pipeline state per instruction
// and interleaves launched warps at instruction granularity.
module warp_scheduler
    import warp_scheduler_pkg::*;
#(
    parameter int NUM_WARPS  = NUM_WARPS_DEFAULT,
    parameter int WARP_IDX_W = $clog2(NUM_WARPS)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [NUM_WARPS-1:0]  warp_valid_mask,
    output logic                  fetch_req,
    input  logic                  fetch_ready,
    input  logic                  decoded_halt,
    input  logic                  decoded_mem_access,
    input  logic                  lsu_done,
    output logic [WARP_IDX_W-1:0] active_warp,
    output logic [NUM_WARPS-1:0]  warp_enable,
    output warp_state_t           warp_state,
    output logic [NUM_WARPS-1:0]  warp_done_mask,
    output logic                  done
);

    warp_state_t           state, state_next;
    logic [WARP_IDX_W-1:0] active_next;
    logic [NUM_WARPS-1:0]  pending, pending_next;
    logic [NUM_WARPS-1:0]  done_mask_next;
    logic [NUM_WARPS-1:0]  active_onehot;
    logic                  idle_or_done;
    logic [NUM_WARPS-1:0]  pick_mask;
    logic [WARP_IDX_W-1:0] pick_cur;
    logic [WARP_IDX_W-1:0] pick_idx;
    logic                  pick_found;

    assign active_onehot = NUM_WARPS'(1) << active_warp;
    assign idle_or_done  = (state == WARP_IDLE) || (state == WARP_DONE);

    // Picker inputs: on launch search from the top index so the lowest valid warp wins;
    // on a halt the halting warp is already excluded from the candidates.
    always_comb begin
        pick_mask = pending;
        pick_cur  = active_warp;
        if (idle_or_done) begin
            pick_mask = warp_valid_mask;
            pick_cur  = '1;
        end else if (state == WARP_DECODE) begin
            pick_mask = pending & ~active_onehot;
        end
    end

    warp_scheduler_rr_picker #(
        .N (NUM_WARPS),
        .W (WARP_IDX_W)
    ) rr_picker (
        .req_mask (pick_mask),
        .cur_idx  (pick_cur),
        .found    (pick_found),
        .next_idx (pick_idx)
    );

    // Register state, current warp and the pending/halted bookkeeping.
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= WARP_IDLE;
            active_warp    <= '0;
            pending        <= '0;
            warp_done_mask <= '0;
        end else begin
            state          <= state_next;
            active_warp    <= active_next;
            pending        <= pending_next;
            warp_done_mask <= done_mask_next;
        end
    end

    // Next-state logic: instruction pipeline walk plus warp hand-off at UPDATE or halt.
    always_comb begin
        state_next     = state;
        active_next    = active_warp;
        pending_next   = pending;
        done_mask_next = warp_done_mask;
        case (state)
            WARP_IDLE, WARP_DONE: begin
                if (start) begin
                    pending_next   = warp_valid_mask;
                    done_mask_next = '0;
                    if (pick_found) begin
                        active_next = pick_idx;
                        state_next  = WARP_FETCH;
                    end else begin
                        state_next  = WARP_DONE;
                    end
                end
            end
            WARP_FETCH: begin
                if (fetch_ready) state_next = WARP_DECODE;
            end
            WARP_DECODE: begin
                if (decoded_halt) begin
                    pending_next   = pending & ~active_onehot;
                    done_mask_next = warp_done_mask | active_onehot;
                    if (pick_found) begin
                        active_next = pick_idx;
                        state_next  = WARP_FETCH;
                    end else begin
                        state_next  = WARP_DONE;
                    end
                end else begin
                    state_next = WARP_REQUEST;
                end
            end
            WARP_REQUEST: begin
                state_next = decoded_mem_access ? WARP_WAIT : WARP_EXECUTE;
            end
            WARP_WAIT: begin
                if (lsu_done) state_next = WARP_UPDATE;
            end
            WARP_EXECUTE: begin
                state_next = WARP_UPDATE;
            end
            WARP_UPDATE: begin
                if (pick_found) begin
                    active_next = pick_idx;
                    state_next  = WARP_FETCH;
                end else begin
                    state_next  = WARP_DONE;
                end
            end
            default: begin
                state_next = WARP_IDLE;
            end
        endcase
    end

    assign warp_state  = state;
    assign fetch_req   = (state == WARP_FETCH);
    assign done        = (state == WARP_DONE);
    assign warp_enable = idle_or_done ? '0 : active_onehot;

endmodule

// File: tb/tb_warp_scheduler.sv
// Scoreboard bench for warp_scheduler: each scenario queues per-cycle stimulus and the
// expected registered outputs, then replays them cycle by cycle against the DUT.
module tb_warp_scheduler;
    import warp_scheduler_pkg::*;

    logic        clk;
    logic        reset;
    logic        start;
    logic [3:0]  warp_valid_mask;
    logic        fetch_req;
    logic        fetch_ready;
    logic        decoded_halt;
    logic        decoded_mem_access;
    logic        lsu_done;
    logic [1:0]  active_warp;
    logic [3:0]  warp_enable;
    warp_state_t warp_state;
    logic [3:0]  warp_done_mask;
    logic        done;

    typedef struct {
        logic       rst;
        logic       st;
        logic [3:0] mask;
        logic       fr;
        logic       halt;
        logic       mem;
        logic       lsu;
    } stim_t;

    stim_t       stim_q[$];
    logic [14:0] exp_q[$];
    int          tests_run = 0;
    int          failures  = 0;

    warp_scheduler #(.NUM_WARPS(4)) dut (
        .clk                (clk),
        .reset              (reset),
        .start              (start),
        .warp_valid_mask    (warp_valid_mask),
        .fetch_req          (fetch_req),
        .fetch_ready        (fetch_ready),
        .decoded_halt       (decoded_halt),
        .decoded_mem_access (decoded_mem_access),
        .lsu_done           (lsu_done),
        .active_warp        (active_warp),
        .warp_enable        (warp_enable),
        .warp_state         (warp_state),
        .warp_done_mask     (warp_done_mask),
        .done               (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Queue one cycle: inputs for the next rising edge and the outputs expected after it.
    task automatic plan(input logic rst, input logic st, input logic [3:0] mask,
                        input logic fr, input logic halt, input logic mem, input logic lsu,
                        input warp_state_t est, input logic [1:0] ew, input logic [3:0] edm);
        stim_t       s;
        logic [3:0]  en;
        logic [14:0] e;
        s.rst = rst; s.st = st; s.mask = mask; s.fr = fr;
        s.halt = halt; s.mem = mem; s.lsu = lsu;
        stim_q.push_back(s);
        en = (est == WARP_IDLE || est == WARP_DONE) ? 4'b0000 : (4'b0001 << ew);
        e  = {est, ew, en, edm, (est == WARP_DONE), (est == WARP_FETCH)};
        exp_q.push_back(e);
    endtask

    // Queue a full ALU instruction for warp w starting in its FETCH, ending in FETCH of nxt.
    task automatic plan_alu(input logic [1:0] w, input logic [1:0] nxt, input logic [3:0] dm);
        plan(0, 0, 4'b0, 1, 0, 0, 0, WARP_DECODE,  w,   dm);
        plan(0, 0, 4'b0, 1, 0, 0, 0, WARP_REQUEST, w,   dm);
        plan(0, 0, 4'b0, 1, 0, 0, 0, WARP_EXECUTE, w,   dm);
        plan(0, 0, 4'b0, 1, 0, 0, 0, WARP_UPDATE,  w,   dm);
        plan(0, 0, 4'b0, 1, 0, 0, 0, WARP_FETCH,   nxt, dm);
    endtask

    // Queue a halting instruction for warp w starting in its FETCH.
    task automatic plan_halt(input logic [1:0] w, input warp_state_t after, input logic [1:0] nxt,
                             input logic [3:0] dm_after, input logic [3:0] dm_before);
        plan(0, 0, 4'b0, 1, 0, 0, 0, WARP_DECODE, w,   dm_before);
        plan(0, 0, 4'b0, 1, 1, 0, 0, after,       nxt, dm_after);
    endtask

    // Apply the next queued stimulus and advance to the following falling edge.
    task automatic drive_next();
        stim_t s;
        s = stim_q.pop_front();
        reset              = s.rst;
        start              = s.st;
        warp_valid_mask    = s.mask;
        fetch_ready        = s.fr;
        decoded_halt       = s.halt;
        decoded_mem_access = s.mem;
        lsu_done           = s.lsu;
        @(negedge clk);
    endtask

    task automatic test_reset();
        logic [14:0] e, obs;
        int step = 0;
        plan(1, 0, 4'b0, 0, 0, 0, 0, WARP_IDLE, 2'd0, 4'b0000);
        plan(1, 0, 4'b0, 0, 0, 0, 0, WARP_IDLE, 2'd0, 4'b0000);
        plan(0, 0, 4'b0, 0, 0, 0, 0, WARP_IDLE, 2'd0, 4'b0000);
        while (stim_q.size() != 0) begin
            drive_next();
            e   = exp_q.pop_front();
            obs = {warp_state, active_warp, warp_enable, warp_done_mask, done, fetch_req};
            tests_run++;
            if (obs !== e) begin
                failures++;
                $display("[TB] FAIL reset step %0d: got %b, expected %b", step, obs, e);
            end
            step++;
        end
    endtask

    task automatic test_launch();
        logic [14:0] e, obs;
        int step = 0;
        plan(0, 1, 4'b0101, 1, 0, 0, 0, WARP_FETCH, 2'd0, 4'b0000);
        plan_alu(2'd0, 2'd2, 4'b0000);
        plan_alu(2'd2, 2'd0, 4'b0000);
        plan_alu(2'd0, 2'd2, 4'b0000);
        plan_alu(2'd2, 2'd0, 4'b0000);
        plan_halt(2'd0, WARP_FETCH, 2'd2, 4'b0001, 4'b0000);
        plan_halt(2'd2, WARP_DONE,  2'd2, 4'b0101, 4'b0001);
        while (stim_q.size() != 0) begin
            drive_next();
            e   = exp_q.pop_front();
            obs = {warp_state, active_warp, warp_enable, warp_done_mask, done, fetch_req};
            tests_run++;
            if (obs !== e) begin
                failures++;
                $display("[TB] FAIL launch step %0d: got %b, expected %b", step, obs, e);
            end
            step++;
        end
    endtask

    task automatic test_fetch_stall_mem();
        logic [14:0] e, obs;
        int step = 0;
        plan(0, 1, 4'b0001, 0, 0, 0, 1, WARP_FETCH,   2'd0, 4'b0000);
        plan(0, 0, 4'b0,    0, 0, 0, 1, WARP_FETCH,   2'd0, 4'b0000);
        plan(0, 0, 4'b0,    0, 0, 0, 1, WARP_FETCH,   2'd0, 4'b0000);
        plan(0, 0, 4'b0,    1, 0, 0, 0, WARP_DECODE,  2'd0, 4'b0000);
        plan(0, 0, 4'b0,    1, 0, 1, 0, WARP_REQUEST, 2'd0, 4'b0000);
        plan(0, 0, 4'b0,    1, 0, 1, 0, WARP_WAIT,    2'd0, 4'b0000);
        plan(0, 0, 4'b0,    1, 0, 1, 0, WARP_WAIT,    2'd0, 4'b0000);
        plan(0, 0, 4'b0,    1, 0, 1, 0, WARP_WAIT,    2'd0, 4'b0000);
        plan(0, 0, 4'b0,    1, 0, 1, 0, WARP_WAIT,    2'd0, 4'b0000);
        plan(0, 0, 4'b0,    0, 0, 0, 1, WARP_UPDATE,  2'd0, 4'b0000);
        plan(0, 0, 4'b0,    0, 0, 0, 1, WARP_FETCH,   2'd0, 4'b0000);
        plan_halt(2'd0, WARP_DONE, 2'd0, 4'b0001, 4'b0000);
        while (stim_q.size() != 0) begin
            drive_next();
            e   = exp_q.pop_front();
            obs = {warp_state, active_warp, warp_enable, warp_done_mask, done, fetch_req};
            tests_run++;
            if (obs !== e) begin
                failures++;
                $display("[TB] FAIL stall_mem step %0d: got %b, expected %b", step, obs, e);
            end
            step++;
        end
    endtask

    task automatic test_halts();
        logic [14:0] e, obs;
        int step = 0;
        plan(0, 1, 4'b1111, 1, 0, 0, 0, WARP_FETCH, 2'd0, 4'b0000);
        plan_alu(2'd0, 2'd1, 4'b0000);
        plan_halt(2'd1, WARP_FETCH, 2'd2, 4'b0010, 4'b0000);
        plan_alu(2'd2, 2'd3, 4'b0010);
        plan_halt(2'd3, WARP_FETCH, 2'd0, 4'b1010, 4'b0010);
        plan_alu(2'd0, 2'd2, 4'b1010);
        plan_alu(2'd2, 2'd0, 4'b1010);
        plan_halt(2'd0, WARP_FETCH, 2'd2, 4'b1011, 4'b1010);
        plan_halt(2'd2, WARP_DONE,  2'd2, 4'b1111, 4'b1011);
        while (stim_q.size() != 0) begin
            drive_next();
            e   = exp_q.pop_front();
            obs = {warp_state, active_warp, warp_enable, warp_done_mask, done, fetch_req};
            tests_run++;
            if (obs !== e) begin
                failures++;
                $display("[TB] FAIL halts step %0d: got %b, expected %b", step, obs, e);
            end
            step++;
        end
    endtask

    task automatic test_empty_launch();
        logic [14:0] e, obs;
        int step = 0;
        plan(0, 1, 4'b0000, 0, 0, 0, 0, WARP_DONE,  2'd2, 4'b0000);
        plan(0, 0, 4'b0000, 0, 0, 0, 0, WARP_DONE,  2'd2, 4'b0000);
        plan(0, 1, 4'b0001, 1, 0, 0, 0, WARP_FETCH, 2'd0, 4'b0000);
        plan_halt(2'd0, WARP_DONE, 2'd0, 4'b0001, 4'b0000);
        while (stim_q.size() != 0) begin
            drive_next();
            e   = exp_q.pop_front();
            obs = {warp_state, active_warp, warp_enable, warp_done_mask, done, fetch_req};
            tests_run++;
            if (obs !== e) begin
                failures++;
                $display("[TB] FAIL empty step %0d: got %b, expected %b", step, obs, e);
            end
            step++;
        end
    endtask

    task automatic test_reset_in_wait();
        logic [14:0] e, obs;
        int step = 0;
        plan(0, 1, 4'b0110, 1, 0, 0, 0, WARP_FETCH,   2'd1, 4'b0000);
        plan_halt(2'd1, WARP_FETCH, 2'd2, 4'b0010, 4'b0000);
        plan(0, 1, 4'b1111, 1, 0, 0, 0, WARP_DECODE,  2'd2, 4'b0010);
        plan(0, 1, 4'b1111, 0, 0, 0, 0, WARP_REQUEST, 2'd2, 4'b0010);
        plan(0, 0, 4'b0,    0, 0, 1, 0, WARP_WAIT,    2'd2, 4'b0010);
        plan(0, 1, 4'b1111, 0, 0, 1, 0, WARP_WAIT,    2'd2, 4'b0010);
        plan(1, 0, 4'b0,    0, 0, 1, 1, WARP_IDLE,    2'd0, 4'b0000);
        plan(0, 0, 4'b0,    0, 0, 0, 1, WARP_IDLE,    2'd0, 4'b0000);
        plan(0, 1, 4'b0010, 1, 0, 0, 0, WARP_FETCH,   2'd1, 4'b0000);
        plan_halt(2'd1, WARP_DONE, 2'd1, 4'b0010, 4'b0000);
        while (stim_q.size() != 0) begin
            drive_next();
            e   = exp_q.pop_front();
            obs = {warp_state, active_warp, warp_enable, warp_done_mask, done, fetch_req};
            tests_run++;
            if (obs !== e) begin
                failures++;
                $display("[TB] FAIL reset_wait step %0d: got %b, expected %b", step, obs, e);
            end
            step++;
        end
    endtask

    // Scenarios run back to back; each one starts from where the previous left the DUT.
    initial begin
        reset              = 1'b1;
        start              = 1'b0;
        warp_valid_mask    = 4'b0;
        fetch_ready        = 1'b0;
        decoded_halt       = 1'b0;
        decoded_mem_access = 1'b0;
        lsu_done           = 1'b0;
        test_reset();
        test_launch();
        test_fetch_stall_mem();
        test_halts();
        test_empty_launch();
        test_reset_in_wait();
        $display("[TB] %0d tests run, %0d failed", tests_run, failures);
        $finish;
    end

endmodule
